// File: rtl/fifo_out_pkg.sv
// fifo_out_pkg: FSM encoding and sizing helpers shared by the FIFO output streamer blocks.
package fifo_out_pkg;
   typedef enum logic [2:0] {IDLE, ARB, START, ACK, DONE} state_t;
   function automatic int ch_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   function automatic int tmo_w(input int cyc);
      return cyc > 1 ? $clog2(cyc) : 1;
   endfunction
endpackage

// File: rtl/fifo_out_streamer_if.sv
// fifo_out_streamer_if: FIFO-side and sink-side signals of the streamer; master is the streamer.
interface fifo_out_streamer_if
   import fifo_out_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 4,
   parameter int CH_W   = ch_w(NUM_CH)
);
   logic                     enable;
   logic [NUM_CH-1:0]        fifo_empty;
   logic [NUM_CH-1:0]        fifo_busy;
   logic [NUM_CH*DATA_W-1:0] fifo_data;
   logic [NUM_CH-1:0]        fifo_re;
   logic [DATA_W-1:0]        out_data;
   logic [CH_W-1:0]          out_chan;
   logic                     out_start;
   logic                     out_finish;
   logic                     is_idle;
   logic                     tmo_err;
   modport master (
      input  enable, fifo_empty, fifo_busy, fifo_data, out_finish,
      output fifo_re, out_data, out_chan, out_start, is_idle, tmo_err
   );
   modport slave (
      output enable, fifo_empty, fifo_busy, fifo_data, out_finish,
      input  fifo_re, out_data, out_chan, out_start, is_idle, tmo_err
   );
endinterface

// File: rtl/fifo_out_rr_arb.sv
// fifo_out_rr_arb: picks one eligible channel, round-robin after ptr (ARB_RR=1) or lowest index first.
module fifo_out_rr_arb
   import fifo_out_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int ARB_RR = 1,
   parameter int CH_W   = ch_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] eligible,
   input  logic [CH_W-1:0]   ptr,
   output logic [CH_W-1:0]   grant,
   output logic              valid
);
   logic [CH_W-1:0] idx;
   always_comb begin
      grant = '0;
      idx = '0;
      // Scan from the farthest candidate back so the nearest eligible one is left standing.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = ARB_RR != 0 ? CH_W'((int'(ptr) + i + 1) % NUM_CH) : CH_W'(i);
         if (eligible[idx]) grant = idx;
      end
   end
   assign valid = |eligible;
endmodule

// File: rtl/fifo_out_streamer.sv
// fifo_out_streamer: arbitrates NUM_CH FWFT FIFOs and hands one word at a time to a start/finish sink.
// Defining FIFO_OUT_TMO_EN adds a sink timeout that abandons a stuck transfer and sets tmo_err.
module fifo_out_streamer
   import fifo_out_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int NUM_CH  = 4,
   parameter int ARB_RR  = 1,
   parameter int TMO_CYC = 1024
) (
   input logic clk,
   input logic reset,
   fifo_out_streamer_if.master bus
);
   localparam int CH_W = ch_w(NUM_CH);
   state_t state, state_n;
   logic [CH_W-1:0] ptr, gnt, chan_n;
   logic [NUM_CH-1:0] sel, re_n;
   logic [DATA_W-1:0] word, data_n;
   logic gnt_vld, take, tmo_hit, start_n, idle_n, err_n;

   fifo_out_rr_arb #(.NUM_CH(NUM_CH), .ARB_RR(ARB_RR), .CH_W(CH_W)) u_arb (
      .eligible(~bus.fifo_empty & ~bus.fifo_busy),
      .ptr(ptr),
      .grant(gnt),
      .valid(gnt_vld)
   );

   assign take = state == ARB && bus.enable && bus.out_finish && gnt_vld;

   always_comb begin
      sel = '0;
      word = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         sel[k] = CH_W'(k) == gnt;
         if (sel[k]) word = bus.fifo_data[k*DATA_W +: DATA_W];
      end
   end

`ifdef FIFO_OUT_TMO_EN
   localparam int TW = tmo_w(TMO_CYC);
   logic [TW-1:0] cnt;
   always_ff @(posedge clk)
      cnt <= (reset || !(state inside {ACK, DONE})) ? '0 : cnt + 1'b1;
   // Only a handshake that is still stuck this cycle is abandoned.
   assign tmo_hit = cnt == TW'(TMO_CYC - 1) &&
                    (state == ACK ? bus.out_finish : state == DONE && !bus.out_finish);
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = ARB;
         ARB:     state_n = take ? START : ARB;
         START:   state_n = ACK;
         ACK:     state_n = !bus.out_finish ? DONE : tmo_hit ? ARB : ACK;
         DONE:    state_n = bus.out_finish || tmo_hit ? ARB : DONE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      re_n    = take ? sel : '0;
      data_n  = take ? word : bus.out_data;
      chan_n  = take ? gnt : bus.out_chan;
      start_n = state == START || (state == ACK && bus.out_finish && !tmo_hit);
      idle_n  = state == ARB && !take;
      err_n   = bus.tmo_err || tmo_hit;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         ptr           <= CH_W'(NUM_CH - 1);
         bus.fifo_re   <= '0;
         bus.out_data  <= '0;
         bus.out_chan  <= '0;
         bus.out_start <= 1'b0;
         bus.is_idle   <= 1'b0;
         bus.tmo_err   <= 1'b0;
      end else begin
         state         <= state_n;
         if (take) ptr <= gnt;
         bus.fifo_re   <= re_n;
         bus.out_data  <= data_n;
         bus.out_chan  <= chan_n;
         bus.out_start <= start_n;
         bus.is_idle   <= idle_n;
         bus.tmo_err   <= err_n;
      end
   end
endmodule

// File: tb/tb_fifo_out_streamer.sv
// tb_fifo_out_streamer: round-robin and fixed-priority instances fed by queue FIFO models,
// with a scoreboard of expected (channel, word) pairs checked at every sink start.
module tb_fifo_out_streamer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int tests = 0;
   int fails = 0;
   always #5 clk = ~clk;

   fifo_out_streamer_if #(.DATA_W(8), .NUM_CH(4)) rr_if ();
   fifo_out_streamer_if #(.DATA_W(8), .NUM_CH(4)) fp_if ();

   fifo_out_streamer #(.DATA_W(8), .NUM_CH(4), .ARB_RR(1), .TMO_CYC(16)) dut_rr (
      .clk(clk), .reset(reset), .bus(rr_if.master));
   fifo_out_streamer #(.DATA_W(8), .NUM_CH(4), .ARB_RR(0), .TMO_CYC(16)) dut_fp (
      .clk(clk), .reset(reset), .bus(fp_if.master));

   logic [7:0] q_rr [4][$];
   logic [7:0] q_fp [4][$];
   logic [9:0] exp_rr [$];
   logic [9:0] exp_fp [$];
   logic [9:0] got_rr, want_rr, got_fp, want_fp;
   logic [3:0] rr_pr = '0, fp_pr = '0;
   logic rr_ps = 1'b0, fp_ps = 1'b0;
   bit sink_auto = 1'b1;
   int starts_rr = 0;
   int pops_rr [4] = '{default: 0};

   always @(negedge clk) begin
      if (rr_if.out_start && !rr_ps) begin
         starts_rr++;
         tests++;
         got_rr = {rr_if.out_chan, rr_if.out_data};
         if (exp_rr.size() == 0) begin
            fails++;
            $display("FAIL rr_start: got chan=%0d data=%h, required no transfer", got_rr[9:8], got_rr[7:0]);
         end else begin
            want_rr = exp_rr.pop_front();
            if (got_rr !== want_rr) begin
               fails++;
               $display("FAIL rr_start: got chan=%0d data=%h, required chan=%0d data=%h",
                        got_rr[9:8], got_rr[7:0], want_rr[9:8], want_rr[7:0]);
            end
         end
      end
      rr_ps = rr_if.out_start;
      if (rr_if.fifo_re != 0) begin
         tests++;
         if (!$onehot(rr_if.fifo_re) || rr_pr != 0) begin
            fails++;
            $display("FAIL rr_re_pulse: fifo_re=%b prev=%b, required one-hot for one cycle", rr_if.fifo_re, rr_pr);
         end
         for (int k = 0; k < 4; k++)
            if (rr_if.fifo_re[k]) begin
               if (q_rr[k].size() == 0) begin
                  fails++;
                  $display("FAIL rr_pop: pop of empty ch%0d, required no pop", k);
               end else begin
                  if (rr_if.out_data !== q_rr[k][0] || rr_if.out_chan !== 2'(k)) begin
                     fails++;
                     $display("FAIL rr_pop: latched chan=%0d data=%h, required chan=%0d data=%h",
                              rr_if.out_chan, rr_if.out_data, k, q_rr[k][0]);
                  end
                  void'(q_rr[k].pop_front());
                  pops_rr[k]++;
               end
            end
      end
      rr_pr = rr_if.fifo_re;
      if (sink_auto) begin
         if (rr_if.out_start && rr_if.out_finish) rr_if.out_finish = 1'b0;
         else if (!rr_if.out_start) rr_if.out_finish = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
         rr_if.fifo_empty[k] = q_rr[k].size() == 0;
         rr_if.fifo_data[k*8 +: 8] = q_rr[k].size() != 0 ? q_rr[k][0] : 8'h00;
      end
   end

   always @(negedge clk) begin
      if (fp_if.out_start && !fp_ps) begin
         tests++;
         got_fp = {fp_if.out_chan, fp_if.out_data};
         if (exp_fp.size() == 0) begin
            fails++;
            $display("FAIL fp_start: got chan=%0d data=%h, required no transfer", got_fp[9:8], got_fp[7:0]);
         end else begin
            want_fp = exp_fp.pop_front();
            if (got_fp !== want_fp) begin
               fails++;
               $display("FAIL fp_start: got chan=%0d data=%h, required chan=%0d data=%h",
                        got_fp[9:8], got_fp[7:0], want_fp[9:8], want_fp[7:0]);
            end
         end
      end
      fp_ps = fp_if.out_start;
      if (fp_if.fifo_re != 0) begin
         tests++;
         if (!$onehot(fp_if.fifo_re) || fp_pr != 0) begin
            fails++;
            $display("FAIL fp_re_pulse: fifo_re=%b prev=%b, required one-hot for one cycle", fp_if.fifo_re, fp_pr);
         end
         for (int k = 0; k < 4; k++)
            if (fp_if.fifo_re[k]) begin
               if (q_fp[k].size() == 0) begin
                  fails++;
                  $display("FAIL fp_pop: pop of empty ch%0d, required no pop", k);
               end else void'(q_fp[k].pop_front());
            end
      end
      fp_pr = fp_if.fifo_re;
      if (fp_if.out_start && fp_if.out_finish) fp_if.out_finish = 1'b0;
      else if (!fp_if.out_start) fp_if.out_finish = 1'b1;
      for (int k = 0; k < 4; k++) begin
         fp_if.fifo_empty[k] = q_fp[k].size() == 0;
         fp_if.fifo_data[k*8 +: 8] = q_fp[k].size() != 0 ? q_fp[k][0] : 8'h00;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
   endtask

   task automatic wait_re(output bit ok);
      int n = 0;
      while (rr_if.fifo_re == 0 && n < 50) begin
         tick();
         n++;
      end
      ok = rr_if.fifo_re != 0;
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL wait_re: fifo_re=%b after 50 cycles, required a pop", rr_if.fifo_re);
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      tick(2);
      while ((exp_rr.size() != 0 || exp_fp.size() != 0 || !rr_if.is_idle || !fp_if.is_idle) && n < 400) begin
         tick();
         n++;
      end
      tests++;
      if (n >= 400) begin
         fails++;
         $display("FAIL %s_drain: %0d rr / %0d fp words pending after 400 cycles, required 0",
                  name, exp_rr.size(), exp_fp.size());
      end
   endtask

   task automatic test_reset;
      tick(3);
      tests++;
      if ({rr_if.fifo_re, rr_if.out_start, rr_if.out_data, rr_if.out_chan, rr_if.is_idle, rr_if.tmo_err} !== '0) begin
         fails++;
         $display("FAIL reset_rr: re=%b start=%b data=%h chan=%0d idle=%b err=%b, required all 0",
                  rr_if.fifo_re, rr_if.out_start, rr_if.out_data, rr_if.out_chan, rr_if.is_idle, rr_if.tmo_err);
      end
      tests++;
      if ({fp_if.fifo_re, fp_if.out_start, fp_if.out_data, fp_if.out_chan, fp_if.is_idle, fp_if.tmo_err} !== '0) begin
         fails++;
         $display("FAIL reset_fp: re=%b start=%b data=%h chan=%0d idle=%b err=%b, required all 0",
                  fp_if.fifo_re, fp_if.out_start, fp_if.out_data, fp_if.out_chan, fp_if.is_idle, fp_if.tmo_err);
      end
      reset = 1'b0;
      tick();
      tests++;
      if (rr_if.is_idle !== 1'b0) begin
         fails++;
         $display("FAIL idle_after_idle_state: is_idle=%b, required 0", rr_if.is_idle);
      end
      tick();
      tests++;
      if (rr_if.is_idle !== 1'b1 || fp_if.is_idle !== 1'b1) begin
         fails++;
         $display("FAIL idle_in_arb: rr=%b fp=%b, required 1 1", rr_if.is_idle, fp_if.is_idle);
      end
   endtask

   task automatic test_single;
      bit ok;
      sink_auto = 1'b0;
      rr_if.out_finish = 1'b1;
      q_rr[0].push_back(8'hA5);
      exp_rr.push_back({2'd0, 8'hA5});
      wait_re(ok);
      tests++;
      if (rr_if.fifo_re !== 4'b0001) begin
         fails++;
         $display("FAIL single_re: fifo_re=%b, required 0001", rr_if.fifo_re);
      end
      tests++;
      if (rr_if.out_data !== 8'hA5 || rr_if.out_chan !== 2'd0) begin
         fails++;
         $display("FAIL single_data: data=%h chan=%0d, required a5 0", rr_if.out_data, rr_if.out_chan);
      end
      tick();
      tests++;
      if (rr_if.fifo_re !== 4'b0000 || rr_if.out_start !== 1'b1) begin
         fails++;
         $display("FAIL single_start: re=%b start=%b, required 0000 1", rr_if.fifo_re, rr_if.out_start);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (rr_if.out_start !== 1'b1) begin
            fails++;
            $display("FAIL single_hold: out_start=%b at hold cycle %0d, required 1", rr_if.out_start, i);
         end
      end
      rr_if.out_finish = 1'b0;
      tick();
      tests++;
      if (rr_if.out_start !== 1'b0) begin
         fails++;
         $display("FAIL single_drop: out_start=%b after finish fell, required 0", rr_if.out_start);
      end
      rr_if.out_finish = 1'b1;
      sink_auto = 1'b1;
      wait_drain("single");
   endtask

   task automatic test_order;
      do_reset();
      for (int j = 0; j < 2; j++)
         for (int k = 0; k < 4; k++) begin
            q_rr[k].push_back(8'(16 * k + j + 1));
            q_fp[k].push_back(8'(16 * k + j + 1));
            exp_rr.push_back({2'(k), 8'(16 * k + j + 1)});
         end
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 2; j++)
            exp_fp.push_back({2'(k), 8'(16 * k + j + 1)});
      wait_drain("order");
   endtask

   task automatic test_busy;
      int p = pops_rr[2];
      rr_if.fifo_busy[2] = 1'b1;
      q_rr[2].push_back(8'hC2);
      exp_rr.push_back({2'd2, 8'hC2});
      for (int i = 0; i < 10; i++) begin
         tick();
         tests++;
         if (rr_if.fifo_re !== 4'b0000 || rr_if.out_start !== 1'b0) begin
            fails++;
            $display("FAIL busy_hold: re=%b start=%b at cycle %0d, required 0000 0", rr_if.fifo_re, rr_if.out_start, i);
         end
      end
      rr_if.fifo_busy[2] = 1'b0;
      wait_drain("busy");
      tick(5);
      tests++;
      if (pops_rr[2] - p !== 1) begin
         fails++;
         $display("FAIL busy_pops: %0d pops of ch2, required 1", pops_rr[2] - p);
      end
   endtask

   task automatic test_enable;
      bit ok;
      int s = starts_rr;
      sink_auto = 1'b0;
      rr_if.out_finish = 1'b1;
      q_rr[1].push_back(8'h51);
      q_rr[1].push_back(8'h52);
      exp_rr.push_back({2'd1, 8'h51});
      exp_rr.push_back({2'd1, 8'h52});
      wait_re(ok);
      tick();
      rr_if.enable = 1'b0;
      tick(2);
      rr_if.out_finish = 1'b0;
      tick();
      rr_if.out_finish = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         tests++;
         if (rr_if.fifo_re !== 4'b0000) begin
            fails++;
            $display("FAIL enable_gate: fifo_re=%b with enable low, required 0000", rr_if.fifo_re);
         end
      end
      tests++;
      if (starts_rr - s !== 1) begin
         fails++;
         $display("FAIL enable_starts: %0d starts, required 1", starts_rr - s);
      end
      tests++;
      if (rr_if.is_idle !== 1'b1) begin
         fails++;
         $display("FAIL enable_idle: is_idle=%b, required 1", rr_if.is_idle);
      end
      rr_if.enable = 1'b1;
      sink_auto = 1'b1;
      wait_drain("enable");
   endtask

   task automatic test_reset_ack;
      bit ok;
      sink_auto = 1'b0;
      rr_if.out_finish = 1'b1;
      q_rr[1].push_back(8'h1D);
      exp_rr.push_back({2'd1, 8'h1D});
      wait_re(ok);
      tick();
      tests++;
      if (rr_if.out_start !== 1'b1) begin
         fails++;
         $display("FAIL rst_ack_pre: out_start=%b, required 1", rr_if.out_start);
      end
      reset = 1'b1;
      tick();
      tests++;
      if ({rr_if.fifo_re, rr_if.out_start, rr_if.is_idle} !== 6'b0) begin
         fails++;
         $display("FAIL rst_ack: re=%b start=%b idle=%b, required 0000 0 0",
                  rr_if.fifo_re, rr_if.out_start, rr_if.is_idle);
      end
      tick();
      reset = 1'b0;
      sink_auto = 1'b1;
      q_rr[2].push_back(8'h2E);
      q_rr[0].push_back(8'h0E);
      exp_rr.push_back({2'd0, 8'h0E});
      exp_rr.push_back({2'd2, 8'h2E});
      wait_drain("rst_ptr");
   endtask

   task automatic test_timeout;
      bit ok;
      int n = 0;
      sink_auto = 1'b0;
      rr_if.out_finish = 1'b1;
      q_rr[0].push_back(8'h77);
      q_rr[1].push_back(8'h78);
      exp_rr.push_back({2'd0, 8'h77});
      exp_rr.push_back({2'd1, 8'h78});
      wait_re(ok);
      tick();
      while (rr_if.out_start && n < 40) begin
         n++;
         tick();
      end
`ifdef FIFO_OUT_TMO_EN
      tests++;
      if (n !== 16) begin
         fails++;
         $display("FAIL tmo_len: out_start high %0d cycles, required 16", n);
      end
      tests++;
      if (rr_if.tmo_err !== 1'b1) begin
         fails++;
         $display("FAIL tmo_err: tmo_err=%b, required 1", rr_if.tmo_err);
      end
`else
      tests++;
      if (n !== 40) begin
         fails++;
         $display("FAIL tmo_hang: out_start high %0d cycles, required 40 (no timeout)", n);
      end
      tests++;
      if (rr_if.tmo_err !== 1'b0) begin
         fails++;
         $display("FAIL tmo_err: tmo_err=%b, required 0", rr_if.tmo_err);
      end
`endif
      sink_auto = 1'b1;
      wait_drain("tmo");
      tests++;
`ifdef FIFO_OUT_TMO_EN
      if (rr_if.tmo_err !== 1'b1) begin
         fails++;
         $display("FAIL tmo_sticky: tmo_err=%b, required 1", rr_if.tmo_err);
      end
`else
      if (rr_if.tmo_err !== 1'b0) begin
         fails++;
         $display("FAIL tmo_sticky: tmo_err=%b, required 0", rr_if.tmo_err);
      end
`endif
   endtask

   initial begin
      rr_if.enable = 1'b1;
      rr_if.fifo_busy = '0;
      rr_if.fifo_empty = '1;
      rr_if.fifo_data = '0;
      rr_if.out_finish = 1'b1;
      fp_if.enable = 1'b1;
      fp_if.fifo_busy = '0;
      fp_if.fifo_empty = '1;
      fp_if.fifo_data = '0;
      fp_if.out_finish = 1'b1;
      test_reset();
      test_single();
      test_order();
      test_busy();
      test_enable();
      test_reset_ack();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench still running at 200000 ns, required completion");
      $fatal(1, "watchdog expired");
   end
endmodule
